pwm_decode: RTL and testbench

PWM_DECODE -- requirements
Module: pwm_decode

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_sync_edge.sv | 29 ++
 rtl/pwm_decode.sv | 108 ++++++++++
 tb/tb_pwm_decode.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: constants and types shared by the PWM generator and the PWM decoder
package pwm_pkg;
    localparam int          PWM_PERIOD = 2048;
    localparam logic [10:0] NONOVERLAP = 11'h040;

    typedef logic [11:0] meas_t;
    localparam meas_t MEAS_MAX = 12'hfff;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    function automatic meas_t sat_inc(input meas_t v);
        return (v == MEAS_MAX) ? v : v + 12'd1;
    endfunction
endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: synchronizes one asynchronous input and flags its rising and falling edges
module pwm_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic              hist;

    // shift the raw input through the synchronizer, then keep one cycle of history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], raw};
            hist <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~hist;
    assign fall  = ~level & hist;
endmodule

// File: rtl/pwm_decode.sv
// pwm_decode: measures PWM1 high time and period in clk cycles and flags PWM1/PWM2 overlap
module pwm_decode
    import pwm_pkg::*;
#(
    parameter int    SYNC_STAGES = 2,
    parameter meas_t TIMEOUT     = 12'd4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PWM1,
    input  logic        PWM2,
    input  logic        clr_err,
    output logic [11:0] duty_meas,
    output logic [11:0] period_meas,
    output logic        meas_vld,
    output logic        stale,
    output logic        ovlp_err
);
    logic   p1_level, p1_rise, p1_fall;
    logic   p2_level, p2_rise, p2_fall;
    logic   unused_p2;
    logic   rise_q, fall_q;
    state_t state, state_nxt;
    meas_t  cnt, high_cnt;
    logic   start, grab, load, expire;

    pwm_sync_edge #(.STAGES(SYNC_STAGES)) u_sync1 (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (PWM1),
        .level(p1_level),
        .rise (p1_rise),
        .fall (p1_fall)
    );

    pwm_sync_edge #(.STAGES(SYNC_STAGES)) u_sync2 (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (PWM2),
        .level(p2_level),
        .rise (p2_rise),
        .fall (p2_fall)
    );

    assign unused_p2 = p2_rise | p2_fall;

    // register PWM1 edges so the FSM sees them one cycle after detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= p1_rise;
            fall_q <= p1_fall;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: awaited edge wins over the timeout, unexpected edges are ignored
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = rise_q ? HIGH : IDLE;
            HIGH:    state_nxt = fall_q ? LOW  : (cnt >= TIMEOUT) ? IDLE : HIGH;
            LOW:     state_nxt = rise_q ? HIGH : (cnt >= TIMEOUT) ? IDLE : LOW;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: datapath strobes decoded from state and edges
    always_comb begin
        start  = rise_q && (state == IDLE || state == LOW);
        grab   = fall_q && (state == HIGH);
        load   = rise_q && (state == LOW);
        expire = (cnt >= TIMEOUT) && ((state == HIGH && !fall_q) || (state == LOW && !rise_q));
    end

    // counters and measurement registers; a timeout reports the stuck level instead of a period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            high_cnt    <= '0;
            duty_meas   <= '0;
            period_meas <= '0;
            meas_vld    <= 1'b0;
            stale       <= 1'b1;
        end else begin
            cnt         <= start ? 12'd1 : (state == IDLE) ? cnt : sat_inc(cnt);
            high_cnt    <= grab ? cnt : high_cnt;
            duty_meas   <= load ? high_cnt : expire ? {12{p1_level}} : duty_meas;
            period_meas <= load ? cnt : expire ? 12'd0 : period_meas;
            meas_vld    <= load;
            stale       <= load ? 1'b0 : expire ? 1'b1 : stale;
        end
    end

    // sticky overlap flag; a fresh overlap beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 ovlp_err <= 1'b0;
        else if (p1_level & p2_level) ovlp_err <= 1'b1;
        else if (clr_err)           ovlp_err <= 1'b0;
    end
endmodule

// File: tb/tb_pwm_decode.sv
// tb_pwm_decode: randomized and directed checks of pwm_decode against an edge-time reference model
module tb_pwm_decode;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 2;
    localparam int TMO  = 4095;

    typedef struct {bit p1; bit p2; int len;} seg_t;
    typedef struct {int cyc; int duty; int period;} ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PWM1 = 1'b0;
    logic        PWM2 = 1'b0;
    logic        clr_err = 1'b0;
    logic [11:0] duty_meas, period_meas;
    logic        meas_vld, stale, ovlp_err;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   stale_cyc = -1;
    logic stale_d = 1'b1;
    seg_t segs[$];
    ev_t  obs_q[$];
    ev_t  exp_q[$];

    pwm_decode #(.SYNC_STAGES(SYNC), .TIMEOUT(12'd4095)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PWM1       (PWM1),
        .PWM2       (PWM2),
        .clr_err    (clr_err),
        .duty_meas  (duty_meas),
        .period_meas(period_meas),
        .meas_vld   (meas_vld),
        .stale      (stale),
        .ovlp_err   (ovlp_err)
    );

    always #5 clk = ~clk;

    // count rising edges; inputs driven #1 after edge k are stamped with cycle k
    always @(posedge clk) cyc <= cyc + 1;

    // record every measurement pulse and the cycle stale last went high
    always @(negedge clk) begin
        if (meas_vld) obs_q.push_back('{cyc, int'(duty_meas), int'(period_meas)});
        if (stale && !stale_d) stale_cyc = cyc;
        stale_d <= stale;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1);
    end

    task automatic apply_reset;
        rst_n = 1'b0; PWM1 = 1'b0; PWM2 = 1'b0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // drive the segment list one cycle per level step, then idle long enough for the last pulse
    task automatic play(output int start);
        start = -1;
        obs_q.delete();
        foreach (segs[j]) begin
            for (int i = 0; i < segs[j].len; i++) begin
                @(posedge clk); #1;
                if (start < 0) start = cyc;
                PWM1 = segs[j].p1;
                PWM2 = segs[j].p2;
            end
        end
        repeat (LAT + 4) @(posedge clk);
        @(negedge clk);
    endtask

    // reference: every rise closes a period if the high and whole period both fit within TIMEOUT
    function automatic void model(input int start);
        bit prev = 1'b0;
        int t = 0, lr = -1, lf = -1;
        exp_q.delete();
        foreach (segs[j]) begin
            if (segs[j].p1 && !prev) begin
                if (lr >= 0 && lf > lr && lf - lr <= TMO && t - lr <= TMO)
                    exp_q.push_back('{start + t + LAT, lf - lr, t - lr});
                lr = t;
            end
            if (!segs[j].p1 && prev) lf = t;
            prev = segs[j].p1;
            t += segs[j].len;
        end
    endfunction

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_tests += 5;
        if (duty_meas !== 12'd0)   begin n_fail++; $display("FAIL reset_duty: got %0d want 0", duty_meas); end
        if (period_meas !== 12'd0) begin n_fail++; $display("FAIL reset_period: got %0d want 0", period_meas); end
        if (meas_vld !== 1'b0)     begin n_fail++; $display("FAIL reset_vld: got %b want 0", meas_vld); end
        if (stale !== 1'b1)        begin n_fail++; $display("FAIL reset_stale: got %b want 1", stale); end
        if (ovlp_err !== 1'b0)     begin n_fail++; $display("FAIL reset_ovlp: got %b want 0", ovlp_err); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++;
        if (stale !== 1'b1) begin n_fail++; $display("FAIL reset_release_stale: got %b want 1", stale); end
    endtask

    task automatic test_nominal;
        int st;
        apply_reset;
        segs.delete();
        segs.push_back('{1'b0, 1'b0, 5});
        for (int p = 0; p < 3; p++) begin
            segs.push_back('{1'b1, 1'b0, 937});
            segs.push_back('{1'b0, 1'b0, 64});
            segs.push_back('{1'b0, 1'b1, 983});
            segs.push_back('{1'b0, 1'b0, 64});
        end
        segs.push_back('{1'b1, 1'b0, 1});
        play(st);
        model(st);
        n_tests++;
        if (obs_q.size() != exp_q.size())
            begin n_fail++; $display("FAIL nominal_count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].duty !== exp_q[i].duty || obs_q[i].period !== exp_q[i].period)
                begin n_fail++; $display("FAIL nominal_ev%0d: got cyc %0d duty %0d period %0d want cyc %0d duty %0d period %0d",
                    i, obs_q[i].cyc, obs_q[i].duty, obs_q[i].period, exp_q[i].cyc, exp_q[i].duty, exp_q[i].period); end
        end
        n_tests += 2;
        if (duty_meas !== 12'd937 || period_meas !== 12'd2048)
            begin n_fail++; $display("FAIL nominal_values: got %0d/%0d want 937/2048", duty_meas, period_meas); end
        if (ovlp_err !== 1'b0) begin n_fail++; $display("FAIL nominal_ovlp: got %b want 0", ovlp_err); end
    endtask

    task automatic test_min_pulse;
        int st;
        apply_reset;
        segs.delete();
        segs.push_back('{1'b0, 1'b0, 2});
        for (int p = 0; p < 5; p++) begin
            segs.push_back('{1'b1, 1'b0, 1});
            segs.push_back('{1'b0, 1'b0, 3});
        end
        segs.push_back('{1'b1, 1'b0, 1});
        play(st);
        model(st);
        n_tests++;
        if (obs_q.size() != exp_q.size())
            begin n_fail++; $display("FAIL minpulse_count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].duty !== exp_q[i].duty || obs_q[i].period !== exp_q[i].period)
                begin n_fail++; $display("FAIL minpulse_ev%0d: got cyc %0d duty %0d period %0d want cyc %0d duty %0d period %0d",
                    i, obs_q[i].cyc, obs_q[i].duty, obs_q[i].period, exp_q[i].cyc, exp_q[i].duty, exp_q[i].period); end
        end
        if (obs_q.size() > 0) begin
            n_tests++;
            if (obs_q[0].cyc - (st + 6) !== LAT)
                begin n_fail++; $display("FAIL minpulse_latency: got %0d cycles want %0d", obs_q[0].cyc - (st + 6), LAT); end
        end
    endtask

    task automatic test_random;
        int st, h, l;
        apply_reset;
        segs.delete();
        segs.push_back('{1'b0, 1'b0, 2});
        for (int p = 0; p < 8; p++) begin
            h = int'($urandom_range(1, 300));
            l = int'($urandom_range(1, 300));
            segs.push_back('{1'b1, 1'b0, h});
            if (l >= 3) begin
                segs.push_back('{1'b0, 1'b0, 1});
                segs.push_back('{1'b0, 1'b1, l - 2});
                segs.push_back('{1'b0, 1'b0, 1});
            end else segs.push_back('{1'b0, 1'b0, l});
        end
        segs.push_back('{1'b1, 1'b0, 1});
        play(st);
        model(st);
        n_tests++;
        if (obs_q.size() != exp_q.size())
            begin n_fail++; $display("FAIL random_count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].duty !== exp_q[i].duty || obs_q[i].period !== exp_q[i].period)
                begin n_fail++; $display("FAIL random_ev%0d: got cyc %0d duty %0d period %0d want cyc %0d duty %0d period %0d",
                    i, obs_q[i].cyc, obs_q[i].duty, obs_q[i].period, exp_q[i].cyc, exp_q[i].duty, exp_q[i].period); end
        end
        n_tests++;
        if (ovlp_err !== 1'b0) begin n_fail++; $display("FAIL random_ovlp: got %b want 0", ovlp_err); end
    endtask

    task automatic test_timeout;
        int st;
        apply_reset;
        segs.delete();
        segs.push_back('{1'b0, 1'b0, 3});
        segs.push_back('{1'b1, 1'b0, 100});
        segs.push_back('{1'b0, 1'b0, 100});
        segs.push_back('{1'b1, 1'b0, 5000});
        stale_cyc = -1;
        play(st);
        model(st);
        n_tests++;
        if (obs_q.size() != exp_q.size())
            begin n_fail++; $display("FAIL timeout_count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].duty !== exp_q[i].duty || obs_q[i].period !== exp_q[i].period)
                begin n_fail++; $display("FAIL timeout_ev%0d: got cyc %0d duty %0d period %0d want cyc %0d duty %0d period %0d",
                    i, obs_q[i].cyc, obs_q[i].duty, obs_q[i].period, exp_q[i].cyc, exp_q[i].duty, exp_q[i].period); end
        end
        n_tests += 4;
        if (stale !== 1'b1) begin n_fail++; $display("FAIL timeout_stale: got %b want 1", stale); end
        if (stale_cyc !== st + 203 + TMO + LAT)
            begin n_fail++; $display("FAIL timeout_stale_cycle: got %0d want %0d", stale_cyc, st + 203 + TMO + LAT); end
        if (duty_meas !== 12'hfff) begin n_fail++; $display("FAIL timeout_duty: got %0d want 4095", duty_meas); end
        if (period_meas !== 12'd0) begin n_fail++; $display("FAIL timeout_period: got %0d want 0", period_meas); end
        segs.delete();
        segs.push_back('{1'b0, 1'b0, 50});
        segs.push_back('{1'b1, 1'b0, 50});
        segs.push_back('{1'b0, 1'b0, 50});
        play(st);
        model(st);
        n_tests += 3;
        if (obs_q.size() != exp_q.size())
            begin n_fail++; $display("FAIL timeout_idle_count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
        if (duty_meas !== 12'hfff || period_meas !== 12'd0)
            begin n_fail++; $display("FAIL timeout_hold: got %0d/%0d want 4095/0", duty_meas, period_meas); end
        if (stale !== 1'b1) begin n_fail++; $display("FAIL timeout_idle_stale: got %b want 1", stale); end
    endtask

    task automatic test_mid_reset;
        int st;
        apply_reset;
        segs.delete();
        segs.push_back('{1'b0, 1'b0, 3});
        segs.push_back('{1'b1, 1'b1, 1});
        segs.push_back('{1'b1, 1'b0, 936});
        segs.push_back('{1'b0, 1'b0, 1111});
        segs.push_back('{1'b1, 1'b0, 992});
        play(st);
        n_tests += 3;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL midreset_pre_count: got %0d pulses want 1", obs_q.size()); end
        if (duty_meas !== 12'd937) begin n_fail++; $display("FAIL midreset_pre_duty: got %0d want 937", duty_meas); end
        if (ovlp_err !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_ovlp: got %b want 1", ovlp_err); end
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        n_tests += 5;
        if (duty_meas !== 12'd0)   begin n_fail++; $display("FAIL midreset_duty: got %0d want 0", duty_meas); end
        if (period_meas !== 12'd0) begin n_fail++; $display("FAIL midreset_period: got %0d want 0", period_meas); end
        if (meas_vld !== 1'b0)     begin n_fail++; $display("FAIL midreset_vld: got %b want 0", meas_vld); end
        if (stale !== 1'b1)        begin n_fail++; $display("FAIL midreset_stale: got %b want 1", stale); end
        if (ovlp_err !== 1'b0)     begin n_fail++; $display("FAIL midreset_ovlp: got %b want 0", ovlp_err); end
        PWM1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        segs.delete();
        segs.push_back('{1'b0, 1'b0, 10});
        for (int p = 0; p < 2; p++) begin
            segs.push_back('{1'b1, 1'b0, 937});
            segs.push_back('{1'b0, 1'b0, 1111});
        end
        segs.push_back('{1'b1, 1'b0, 1});
        play(st);
        model(st);
        n_tests++;
        if (obs_q.size() != exp_q.size())
            begin n_fail++; $display("FAIL midreset_count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_tests++;
            if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].duty !== exp_q[i].duty || obs_q[i].period !== exp_q[i].period)
                begin n_fail++; $display("FAIL midreset_ev%0d: got cyc %0d duty %0d period %0d want cyc %0d duty %0d period %0d",
                    i, obs_q[i].cyc, obs_q[i].duty, obs_q[i].period, exp_q[i].cyc, exp_q[i].duty, exp_q[i].period); end
        end
    endtask

    task automatic test_overlap;
        apply_reset;
        @(posedge clk); #1 PWM1 = 1'b1; PWM2 = 1'b1;
        @(posedge clk); #1 PWM1 = 1'b0; PWM2 = 1'b0;
        repeat (SYNC) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (ovlp_err !== 1'b1) begin n_fail++; $display("FAIL ovlp_set: got %b want 1", ovlp_err); end
        repeat (20) @(negedge clk);
        n_tests++;
        if (ovlp_err !== 1'b1) begin n_fail++; $display("FAIL ovlp_sticky: got %b want 1", ovlp_err); end
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ovlp_err !== 1'b0) begin n_fail++; $display("FAIL ovlp_clear: got %b want 0", ovlp_err); end
        repeat (5) @(posedge clk);
        #1 PWM1 = 1'b1; PWM2 = 1'b1;
        @(posedge clk); #1 PWM1 = 1'b0; PWM2 = 1'b0;
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ovlp_err !== 1'b1) begin n_fail++; $display("FAIL ovlp_set_beats_clear: got %b want 1", ovlp_err); end
        repeat (5) @(negedge clk);
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ovlp_err !== 1'b0) begin n_fail++; $display("FAIL ovlp_clear_again: got %b want 0", ovlp_err); end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_min_pulse;
        test_random;
        test_timeout;
        test_mid_reset;
        test_overlap;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
